data_memory_sized: RTL and testbench

DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

---
 rtl/data_memory_sized.sv | 121 ++++++++++++
 tb/tb_data_memory_sized.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressable 64-bit data memory with RISC-V sized loads/stores.
// Loads return one cycle later; bad requests are reported as one-cycle pulses.
module data_memory_sized #(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [63:0] address,
   input  logic [63:0] write_data,
   output logic [63:0] read_data,
   output logic        read_valid,
   output logic        misaligned,
   output logic        access_fault
);

   logic [63:0] mem_q [DEPTH] = '{default: 64'd0};

   logic [63:0]      readData_q, readData_d;
   logic             readValid_q, readValid_d;
   logic             misaligned_q, misaligned_d;
   logic             accessFault_q, accessFault_d;

   logic [IDX_W-1:0] wordIdx;
   logic [5:0]       bitOff;
   logic             outOfRange;
   logic             misalignedReq;
   logic             reqStore, reqLoad;
   logic             loadOk, storeOk;
   logic [63:0]      sizeMask, laneMask, laneData, storeWord;
   logic [63:0]      curWord, loadShifted, loadValue;

   assign wordIdx    = address[IDX_W+2:3];
   assign bitOff     = {address[2:0], 3'b000};
   // Any set bit above the memory span is out of range; no aliasing.
   assign outOfRange = (address[63:IDX_W+3] != '0);

   assign reqStore = MemWrite;
   assign reqLoad  = MemRead & ~MemWrite;

   always_comb begin
      misalignedReq = 1'b0;
      sizeMask      = 64'hFFFF_FFFF_FFFF_FFFF;
      case (funct3[1:0])
         2'b00: begin
            sizeMask = 64'h0000_0000_0000_00FF;
         end
         2'b01: begin
            sizeMask      = 64'h0000_0000_0000_FFFF;
            misalignedReq = address[0];
         end
         2'b10: begin
            sizeMask      = 64'h0000_0000_FFFF_FFFF;
            misalignedReq = (address[1:0] != 2'b00);
         end
         default: begin
            sizeMask      = 64'hFFFF_FFFF_FFFF_FFFF;
            misalignedReq = (address[2:0] != 3'b000);
         end
      endcase
   end

   assign accessFault_d = (reqStore | reqLoad) &
                          (outOfRange | (reqLoad & (funct3 == 3'b111)));
   assign misaligned_d  = (reqStore | reqLoad) & ~accessFault_d & misalignedReq;
   assign loadOk        = reqLoad & ~accessFault_d & ~misalignedReq;
   assign storeOk       = reqStore & ~reset & ~accessFault_d & ~misalignedReq;
   assign readValid_d   = loadOk;

   assign curWord     = mem_q[wordIdx];
   assign laneMask    = sizeMask << bitOff;
   assign laneData    = write_data << bitOff;
   assign storeWord   = (curWord & ~laneMask) | (laneData & laneMask);
   assign loadShifted = curWord >> bitOff;

   always_comb begin
      loadValue = 64'd0;
      case (funct3)
         3'b000:  loadValue = {{56{loadShifted[7]}},  loadShifted[7:0]};
         3'b001:  loadValue = {{48{loadShifted[15]}}, loadShifted[15:0]};
         3'b010:  loadValue = {{32{loadShifted[31]}}, loadShifted[31:0]};
         3'b011:  loadValue = loadShifted;
         3'b100:  loadValue = {56'd0, loadShifted[7:0]};
         3'b101:  loadValue = {48'd0, loadShifted[15:0]};
         3'b110:  loadValue = {32'd0, loadShifted[31:0]};
         default: loadValue = 64'd0;
      endcase
   end

   assign readData_d = loadOk ? loadValue : readData_q;

   // Memory array has no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (storeOk) begin
         mem_q[wordIdx] <= storeWord;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readData_q    <= 64'd0;
         readValid_q   <= 1'b0;
         misaligned_q  <= 1'b0;
         accessFault_q <= 1'b0;
      end else begin
         readData_q    <= readData_d;
         readValid_q   <= readValid_d;
         misaligned_q  <= misaligned_d;
         accessFault_q <= accessFault_d;
      end
   end

   assign read_data    = readData_q;
   assign read_valid   = readValid_q;
   assign misaligned   = misaligned_q;
   assign access_fault = accessFault_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: a byte-array reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_data_memory_sized;

   localparam int DEPTH = 256;
   localparam longint unsigned SPAN = DEPTH * 8;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [63:0] address;
   logic [63:0] write_data;
   logic [63:0] read_data;
   logic        read_valid;
   logic        misaligned;
   logic        access_fault;

   data_memory_sized #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .funct3       (funct3),
      .address      (address),
      .write_data   (write_data),
      .read_data    (read_data),
      .read_valid   (read_valid),
      .misaligned   (misaligned),
      .access_fault (access_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        mis;
      logic        fault;
      logic [63:0] data;
   } expT;

   expT         expQ[$];
   logic [7:0]  refMem [SPAN];
   logic [63:0] expRd;
   int          vectors;
   int          miscompares;
   bit          stimDone;

   // Reference model: works on individual bytes and plain arithmetic.
   task automatic modelStep(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic rst);
      expT e;
      int unsigned nBytes;
      bit inRange, aligned, isLoad;
      logic [63:0] v;
      e.valid = 1'b0; e.mis = 1'b0; e.fault = 1'b0;
      if (rst) begin
         expRd  = 64'd0;
         e.data = expRd;
         expQ.push_back(e);
         return;
      end
      nBytes  = 1 << f3[1:0];
      inRange = (addr < SPAN);
      aligned = ((addr % nBytes) == 0);
      isLoad  = rd && !wr;
      if (wr) begin
         if (!inRange) e.fault = 1'b1;
         else if (!aligned) e.mis = 1'b1;
         else
            for (int i = 0; i < int'(nBytes); i++)
               refMem[int'(addr) + i] = wd[8*i +: 8];
      end else if (isLoad) begin
         if (!inRange || f3 == 3'b111) e.fault = 1'b1;
         else if (!aligned) e.mis = 1'b1;
         else begin
            v = 64'd0;
            for (int i = 0; i < int'(nBytes); i++)
               v[8*i +: 8] = refMem[int'(addr) + i];
            if (f3[2] == 1'b0 && nBytes < 8 && v[8*nBytes-1])
               for (int b = 8*int'(nBytes); b < 64; b++) v[b] = 1'b1;
            expRd   = v;
            e.valid = 1'b1;
         end
      end
      e.data = expRd;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wd,
                                input logic rst);
      MemRead    = rd;
      MemWrite   = wr;
      funct3     = f3;
      address    = addr;
      write_data = wd;
      reset      = rst;
      @(posedge clk);
      modelStep(rd, wr, f3, addr, wd, rst);
      #1;
   endtask

   task automatic checkOutput(input expT e);
      vectors++;
      if (read_valid !== e.valid || misaligned !== e.mis ||
          access_fault !== e.fault || read_data !== e.data) begin
         miscompares++;
         $display("[TB] FAIL cycle-response: got valid=%b mis=%b fault=%b data=%h, expected valid=%b mis=%b fault=%b data=%h",
                  read_valid, misaligned, access_fault, read_data,
                  e.valid, e.mis, e.fault, e.data);
      end
   endtask

   // Monitor: one expected entry per sampled edge, popped on the following negedge.
   initial begin
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
         end else if (read_valid || misaligned || access_fault) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected-pulse: got valid=%b mis=%b fault=%b, expected none",
                     read_valid, misaligned, access_fault);
         end
      end
   end

   initial begin
      logic [63:0] addr;
      logic [2:0]  f3;
      logic        rd, wr, rst;
      int          sel;
      vectors = 0; miscompares = 0; stimDone = 1'b0;
      expRd = 64'd0;
      for (int i = 0; i < int'(SPAN); i++) refMem[i] = 8'd0;
      MemRead = 0; MemWrite = 0; funct3 = 0; address = 0; write_data = 0; reset = 1;
      @(posedge clk); #1;

      applyStimulus(0, 0, 3'b000, 64'h0, 64'h0, 1);
      applyStimulus(1, 0, 3'b011, 64'h0, 64'h0, 0);
      // Full-word store and readback, then byte overwrite with signed/unsigned word loads.
      applyStimulus(0, 1, 3'b011, 64'h10, 64'h8877665544332211, 0);
      applyStimulus(1, 0, 3'b011, 64'h10, 64'h0, 0);
      applyStimulus(0, 1, 3'b000, 64'h13, 64'h00000000000000FF, 0);
      applyStimulus(1, 0, 3'b010, 64'h10, 64'h0, 0);
      applyStimulus(1, 0, 3'b110, 64'h10, 64'h0, 0);
      applyStimulus(1, 0, 3'b000, 64'h13, 64'h0, 0);
      applyStimulus(1, 0, 3'b101, 64'h12, 64'h0, 0);
      // Misaligned load and store, then confirm memory untouched.
      applyStimulus(1, 0, 3'b001, 64'h11, 64'h0, 0);
      applyStimulus(0, 1, 3'b010, 64'h12, 64'hDEADBEEF, 0);
      applyStimulus(1, 0, 3'b011, 64'h10, 64'h0, 0);
      // Out-of-range and illegal-funct3 faults, including a store using 111 as D.
      applyStimulus(1, 0, 3'b011, 64'h800, 64'h0, 0);
      applyStimulus(1, 0, 3'b111, 64'h0, 64'h0, 0);
      applyStimulus(0, 1, 3'b011, 64'h800, 64'h1234, 0);
      applyStimulus(1, 0, 3'b111, 64'h3, 64'h0, 0);
      applyStimulus(0, 1, 3'b111, 64'h7F8, 64'hCAFEF00D12345678, 0);
      applyStimulus(1, 0, 3'b011, 64'h7F8, 64'h0, 0);
      applyStimulus(1, 0, 3'b011, 64'h8000000000000000, 64'h0, 0);
      // Simultaneous read/write, then reset in the middle of a load stream.
      applyStimulus(1, 1, 3'b000, 64'h20, 64'h5A, 0);
      applyStimulus(1, 0, 3'b000, 64'h20, 64'h0, 0);
      applyStimulus(1, 0, 3'b011, 64'h10, 64'h0, 0);
      applyStimulus(1, 1, 3'b011, 64'h28, 64'h77, 1);
      applyStimulus(1, 0, 3'b011, 64'h18, 64'h0, 0);
      applyStimulus(1, 0, 3'b100, 64'h20, 64'h0, 0);
      applyStimulus(1, 0, 3'b011, 64'h28, 64'h0, 0);

      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 19);
         if (sel < 15)       addr = 64'($urandom_range(0, 127));
         else if (sel < 17)  addr = 64'h7F8 + 64'($urandom_range(0, 7));
         else if (sel < 19)  addr = 64'h800 + 64'($urandom_range(0, 15));
         else                addr = {$urandom, $urandom};
         f3  = 3'($urandom_range(0, 7));
         rd  = 1'($urandom_range(0, 1));
         wr  = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 59) == 0);
         applyStimulus(rd, wr, f3, addr, {$urandom, $urandom}, rst);
      end
      applyStimulus(0, 0, 3'b000, 64'h0, 64'h0, 0);
      stimDone = 1'b1;

      for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain: got %0d pending responses, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
